// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: RV32I width codes,
// the responder FSM state encoding and the byte-lane enable helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Illegal width codes yield no lanes, so a bad request can never write.
  function automatic logic [3:0] byteEnable(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic [3:0] en;
    en = 4'b0000;
    case (funct3)
      F3_B, F3_BU: en = 4'b0001 << addrLo;
      F3_H, F3_HU: en = addrLo[1] ? 4'b1100 : 4'b0011;
      F3_W:        en = 4'b1111;
      default:     en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// Combinational RV32I width handling: byte enables, store lane replication,
// load lane selection with sign/zero extension and misalignment detection.
module mem_align_unit
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byteEn,
  output logic [31:0] o_wdataLane,
  output logic [31:0] o_rdataExt,
  output logic        o_misaligned
);

  logic [31:0] w_byteShift;
  logic [31:0] w_halfShift;

  assign w_byteShift = i_rword >> {i_addrLo, 3'b000};
  assign w_halfShift = i_rword >> {i_addrLo[1], 4'b0000};
  assign o_byteEn    = byteEnable(i_funct3, i_addrLo);

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    o_wdataLane  = i_wdata;
    o_rdataExt   = 32'h0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_wdataLane = {4{i_wdata[7:0]}};
        o_rdataExt  = {{24{w_byteShift[7]}}, w_byteShift[7:0]};
      end
      F3_BU: begin
        o_wdataLane = {4{i_wdata[7:0]}};
        o_rdataExt  = {24'h0, w_byteShift[7:0]};
      end
      F3_H: begin
        o_wdataLane  = {2{i_wdata[15:0]}};
        o_rdataExt   = {{16{w_halfShift[15]}}, w_halfShift[15:0]};
        o_misaligned = i_addrLo[0];
      end
      F3_HU: begin
        o_wdataLane  = {2{i_wdata[15:0]}};
        o_rdataExt   = {16'h0, w_halfShift[15:0]};
        o_misaligned = i_addrLo[0];
      end
      F3_W: begin
        o_wdataLane  = i_wdata;
        o_rdataExt   = i_rword;
        o_misaligned = (i_addrLo != 2'b00);
      end
      default: begin
        o_wdataLane  = i_wdata;
        o_rdataExt   = 32'h0;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready load/store front end with programmable
// wait states in front of a word-organised synchronous RAM.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_rspValid;
  logic [31:0] r_rspRdata;
  logic        r_rspErr;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_access;
  logic        w_we;
  logic [31:0] w_addr;
  logic [2:0]  w_funct3;
  logic [31:0] w_wdata;
  logic [29:0] w_wordIdx;
  logic        w_outOfRange;
  logic        w_badFunct3;
  logic        w_err;
  logic [31:0] w_rword;
  logic [3:0]  w_byteEn;
  logic [31:0] w_wdataLane;
  logic [31:0] w_rdataExt;
  logic        w_misaligned;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request is used while idle and the latched copy otherwise.
  assign w_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;

  assign w_access = reset_n &&
                    (((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((r_state == BUSY) && (r_count == 4'd1)));

  assign w_wordIdx    = w_addr[31:2];
  assign w_outOfRange = (w_wordIdx >= 30'(DEPTH_WORDS));
  assign w_badFunct3  = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
  assign w_err        = w_badFunct3 || (w_we && w_funct3[2]) || w_misaligned || w_outOfRange;
  assign w_rword      = w_outOfRange ? 32'h0 : r_mem[w_wordIdx[IDX_W-1:0]];

  mem_align_unit u_align (
    .i_funct3     (w_funct3),
    .i_addrLo     (w_addr[1:0]),
    .i_wdata      (w_wdata),
    .i_rword      (w_rword),
    .o_byteEn     (w_byteEn),
    .o_wdataLane  (w_wdataLane),
    .o_rdataExt   (w_rdataExt),
    .o_misaligned (w_misaligned)
  );

  // RAM has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (w_access && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) begin
          r_mem[w_wordIdx[IDX_W-1:0]][8*i +: 8] <= w_wdataLane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_funct3   <= 3'b000;
      r_wdata    <= 32'h0;
      r_rspValid <= 1'b0;
      r_rspRdata <= 32'h0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            if (w_access) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= w_err;
              r_rspRdata <= (w_err || w_we) ? 32'h0 : w_rdataExt;
            end else begin
              r_state <= BUSY;
              r_count <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          if (w_access) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspErr   <= w_err;
            r_rspRdata <= (w_err || w_we) ? 32'h0 : w_rdataExt;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0;
            r_rspErr   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with reset_n holds req_ready low during reset yet high right after.
  assign req_ready = reset_n && (r_state == IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with 1, 4 and 0
// wait states share one clock and are exercised through common tasks.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        resetN    [3];
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [31:0] reqAddr   [3];
  logic [2:0]  reqFunct3 [3];
  logic [31:0] reqWdata  [3];
  logic        rspValid  [3];
  logic        rspReady  [3];
  logic [31:0] rspRdata  [3];
  logic        rspErr    [3];

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          latency;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dutW1 (
    .clk(clk), .reset_n(resetN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_funct3(reqFunct3[0]), .req_wdata(reqWdata[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) dutW4 (
    .clk(clk), .reset_n(resetN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_funct3(reqFunct3[1]), .req_wdata(reqWdata[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dutW0 (
    .clk(clk), .reset_n(resetN[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .req_we(reqWe[2]), .req_addr(reqAddr[2]), .req_funct3(reqFunct3[2]), .req_wdata(reqWdata[2]),
    .rsp_valid(rspValid[2]), .rsp_ready(rspReady[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2])
  );

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Presents one request and returns on the falling edge just after the accept edge.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] wdata, output bit accepted);
    int guard;
    guard = 0;
    accepted = 1'b0;
    while (!reqReady[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!reqReady[d]) begin
      checkOutput("acceptTimeout", {31'b0, reqReady[d]}, 32'd1);
      return;
    end
    reqValid[d]  = 1'b1;
    reqWe[d]     = we;
    reqAddr[d]   = addr;
    reqFunct3[d] = f3;
    reqWdata[d]  = wdata;
    @(negedge clk);
    reqValid[d]  = 1'b0;
    reqWe[d]     = 1'($urandom);
    reqAddr[d]   = $urandom;
    reqFunct3[d] = 3'($urandom);
    reqWdata[d]  = $urandom;
    accepted = 1'b1;
  endtask

  task automatic runTxn(input string tag, input int d, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wdata, input logic [31:0] expRdata,
                        input logic expErr, input int expLat, input int holdCycles);
    exp_t e;
    bit   ok;
    int   lat;
    expQ.push_back('{rdata: expRdata, err: expErr, latency: expLat});
    applyStimulus(d, we, addr, f3, wdata, ok);
    e = expQ.pop_front();
    if (!ok) return;
    lat = 1;
    while (!rspValid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(e.latency));
    checkOutput({tag, ".rdata"}, rspRdata[d], e.rdata);
    checkOutput({tag, ".err"}, {31'b0, rspErr[d]}, {31'b0, e.err});
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.holdValid%0d", tag, h), {31'b0, rspValid[d]}, 32'd1);
      checkOutput($sformatf("%s.holdRdata%0d", tag, h), rspRdata[d], e.rdata);
      checkOutput($sformatf("%s.holdErr%0d", tag, h), {31'b0, rspErr[d]}, {31'b0, e.err});
      checkOutput($sformatf("%s.holdReady%0d", tag, h), {31'b0, reqReady[d]}, 32'd0);
    end
    rspReady[d] = 1'b1;
    @(negedge clk);
    rspReady[d] = 1'b0;
    checkOutput({tag, ".backIdle"}, {31'b0, reqReady[d]}, 32'd1);
    checkOutput({tag, ".validDrop"}, {31'b0, rspValid[d]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int seen;
    for (int i = 0; i < 3; i++) begin
      resetN[i] = 1'b0;
      reqValid[i] = 1'b0;
      reqWe[i] = 1'b0;
      reqAddr[i] = 32'h0;
      reqFunct3[i] = 3'b000;
      reqWdata[i] = 32'h0;
      rspReady[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst.reqReady", {31'b0, reqReady[0]}, 32'd0);
    checkOutput("rst.rspValid", {31'b0, rspValid[0]}, 32'd0);
    checkOutput("rst.rspRdata", rspRdata[0], 32'h0);
    checkOutput("rst.rspErr", {31'b0, rspErr[0]}, 32'd0);
    for (int i = 0; i < 3; i++) resetN[i] = 1'b1;
    #1;
    checkOutput("rst.readyAfterRelease", {31'b0, reqReady[0]}, 32'd1);
    @(negedge clk);

    // One wait state: basic store/load, sub-word merge and extension.
    runTxn("sw10",  0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0);
    runTxn("lw10",  0, 1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
    runTxn("sb12",  0, 1'b1, 32'h12, 3'b000, 32'hAAAA_AA55, 32'h0,       1'b0, 2, 0);
    runTxn("lw10b", 0, 1'b0, 32'h10, 3'b010, 32'h0,        32'hDE55BEEF, 1'b0, 2, 0);
    runTxn("lh12",  0, 1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFFDE55, 1'b0, 2, 0);
    runTxn("lhu12", 0, 1'b0, 32'h12, 3'b101, 32'h0,        32'h0000DE55, 1'b0, 2, 0);
    runTxn("sw20",  0, 1'b1, 32'h20, 3'b010, 32'h11223300, 32'h0,        1'b0, 2, 0);
    runTxn("sb20",  0, 1'b1, 32'h20, 3'b000, 32'h00000080, 32'h0,        1'b0, 2, 0);
    runTxn("lb20",  0, 1'b0, 32'h20, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
    runTxn("lbu20", 0, 1'b0, 32'h20, 3'b100, 32'h0,        32'h00000080, 1'b0, 2, 0);
    runTxn("sh22",  0, 1'b1, 32'h16, 3'b001, 32'h0000C3A5, 32'h0,        1'b0, 2, 0);
    runTxn("lw14",  0, 1'b0, 32'h14, 3'b010, 32'h0,        32'hC3A5_0000 | 32'h0, 1'b0, 2, 0);

    // Rejected requests must leave the word at 0x20 untouched.
    runTxn("errSwMis",  0, 1'b1, 32'h22,   3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 0);
    runTxn("errLhMis",  0, 1'b0, 32'h21,   3'b001, 32'h0,        32'h0, 1'b1, 2, 0);
    runTxn("errRange",  0, 1'b0, 32'h1000, 3'b010, 32'h0,        32'h0, 1'b1, 2, 0);
    runTxn("errF3",     0, 1'b0, 32'h20,   3'b011, 32'h0,        32'h0, 1'b1, 2, 0);
    runTxn("errSbu",    0, 1'b1, 32'h20,   3'b100, 32'h000000FF, 32'h0, 1'b1, 2, 0);
    runTxn("errSwRng",  0, 1'b1, 32'h1000, 3'b010, 32'h12345678, 32'h0, 1'b1, 2, 0);
    runTxn("lw20After", 0, 1'b0, 32'h20,   3'b010, 32'h0, 32'h11223380, 1'b0, 2, 0);
    runTxn("lwTop",     0, 1'b0, 32'hFFC,  3'b110, 32'h0,        32'h0, 1'b1, 2, 0);

    // Backpressure: response held three cycles before acceptance.
    runTxn("bp", 0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDE55BEEF, 1'b0, 2, 3);

    // Four wait states: reset while busy discards the store.
    runTxn("w4sw30", 1, 1'b1, 32'h30, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 5, 0);
    applyStimulus(1, 1'b1, 32'h30, 3'b010, 32'h00001234, ok);
    @(negedge clk);
    resetN[1] = 1'b0;
    #1;
    checkOutput("midRst.reqReady", {31'b0, reqReady[1]}, 32'd0);
    checkOutput("midRst.rspValid", {31'b0, rspValid[1]}, 32'd0);
    checkOutput("midRst.rspErr", {31'b0, rspErr[1]}, 32'd0);
    repeat (2) @(negedge clk);
    resetN[1] = 1'b1;
    #1;
    checkOutput("midRst.readyAfter", {31'b0, reqReady[1]}, 32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rspValid[1]) seen++;
    end
    checkOutput("midRst.noResponse", 32'(seen), 32'd0);
    runTxn("w4lw30", 1, 1'b0, 32'h30, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 5, 0);

    // Zero wait states: response the cycle after accept.
    runTxn("w0sw40",  2, 1'b1, 32'h40, 3'b010, 32'h13579BDF, 32'h0,        1'b0, 1, 0);
    runTxn("w0lw40",  2, 1'b0, 32'h40, 3'b010, 32'h0,        32'h13579BDF, 1'b0, 1, 0);
    runTxn("w0lhu42", 2, 1'b0, 32'h42, 3'b101, 32'h0,        32'h00001357, 1'b0, 1, 0);
    runTxn("w0lb43",  2, 1'b0, 32'h43, 3'b000, 32'h0,        32'h00000013, 1'b0, 1, 0);
    runTxn("w0lb41",  2, 1'b0, 32'h41, 3'b000, 32'h0,        32'hFFFFFF9B, 1'b0, 1, 0);
    runTxn("w0err",   2, 1'b0, 32'h41, 3'b010, 32'h0,        32'h0,        1'b1, 1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
